dm_port_arbiter: RTL

Arbitrates the single read/write port of the 1024x32 data memory between two requesters: the CPU load/store path and the SDU debug unit. The SDU's second read-only port is untouched.
- Converts CPU byte addresses to word indices.
- Stalls the CPU while the SDU owns the port.
- Bounds SDU wait time with a starvation counter.
- Supports an SDU lock mode for multi-word debug bursts.

---
 rtl/dm_port_arbiter_if.sv | 51 +++++
 rtl/dm_port_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter_if.sv
// Data-memory port bundle: CPU and SDU requester
// channels plus the single RW memory port.
interface dm_port_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic [31:0]       cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_err;

  logic              sdu_req;
  logic              sdu_we;
  logic [ADDR_W-1:0] sdu_addr;
  logic [31:0]       sdu_wdata;
  logic              sdu_lock;
  logic              sdu_gnt;
  logic [31:0]       sdu_rdata;
  logic              sdu_rvalid;

  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_d;
  logic              mem_we;
  logic [31:0]       mem_spo;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rdata,
    output cpu_rvalid, cpu_err,
    input  sdu_req, sdu_we, sdu_addr, sdu_wdata,
    input  sdu_lock,
    output sdu_gnt, sdu_rdata, sdu_rvalid,
    output mem_a, mem_d, mem_we,
    input  mem_spo
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rdata,
    input  cpu_rvalid, cpu_err,
    output sdu_req, sdu_we, sdu_addr, sdu_wdata,
    output sdu_lock,
    input  sdu_gnt, sdu_rdata, sdu_rvalid,
    input  mem_a, mem_d, mem_we,
    output mem_spo
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Data-memory RW port arbiter: CPU vs SDU with
// starvation bound and SDU lock bursts.
module dm_port_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int          ADDR_W    = 10,
  parameter int          MAX_WAIT  = 8
) (
  input  logic             clk,
  input  logic             rst,
  dm_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    ARB,
    LOCK
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0]   off;
  logic          bad;
  logic          starved;
  logic          cpu_gnt;
  logic          sdu_gnt;

  logic [31:0]   cpu_rdata_q;
  logic          cpu_rvalid_q;
  logic          cpu_err_q;
  logic [31:0]   sdu_rdata_q;
  logic          sdu_rvalid_q;

  // Offset wraps, so addresses below BASE_ADDR
  // land far above the window and read as bad.
  assign off = bus.cpu_addr - BASE_ADDR;
  assign bad = (off[1:0] != 2'b00)
             | ((off >> (ADDR_W + 2)) != 32'd0);
  assign starved = (cnt == CW'(MAX_WAIT));

  always_comb begin
    cpu_gnt  = 1'b0;
    sdu_gnt  = 1'b0;
    state_nx = state;
    case (state)
      ARB: begin
        if (bus.sdu_req && starved)
          sdu_gnt = 1'b1;
        else if (bus.cpu_req)
          cpu_gnt = 1'b1;
        else if (bus.sdu_req)
          sdu_gnt = 1'b1;
        if (sdu_gnt && bus.sdu_lock)
          state_nx = LOCK;
      end
      LOCK: begin
        sdu_gnt = bus.sdu_req;
        if (!bus.sdu_lock)
          state_nx = ARB;
      end
      default: state_nx = ARB;
    endcase
    // Reset is asynchronous, so grants must
    // also die combinationally while it is held.
    if (rst) begin
      cpu_gnt = 1'b0;
      sdu_gnt = 1'b0;
    end
  end

  always_comb begin
    cnt_nx = cnt;
    if (sdu_gnt)
      cnt_nx = '0;
    else if (bus.sdu_req && !starved)
      cnt_nx = cnt + 1'b1;
  end

  always_comb begin
    bus.mem_a  = '0;
    bus.mem_d  = '0;
    bus.mem_we = 1'b0;
    if (cpu_gnt) begin
      bus.mem_a  = off[ADDR_W+1:2];
      bus.mem_d  = bus.cpu_wdata;
      bus.mem_we = bus.cpu_we & ~bad;
    end else if (sdu_gnt) begin
      bus.mem_a  = bus.sdu_addr;
      bus.mem_d  = bus.sdu_wdata;
      bus.mem_we = bus.sdu_we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARB;
      cnt          <= '0;
      cpu_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      sdu_rdata_q  <= '0;
      sdu_rvalid_q <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      cpu_rvalid_q <= cpu_gnt & ~bus.cpu_we;
      cpu_err_q    <= cpu_gnt & bad;
      sdu_rvalid_q <= sdu_gnt & ~bus.sdu_we;
      if (cpu_gnt && !bus.cpu_we)
        cpu_rdata_q <= bad ? 32'd0 : bus.mem_spo;
      if (sdu_gnt && !bus.sdu_we)
        sdu_rdata_q <= bus.mem_spo;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.cpu_err    = cpu_err_q;
  assign bus.sdu_gnt    = sdu_gnt;
  assign bus.sdu_rdata  = sdu_rdata_q;
  assign bus.sdu_rvalid = sdu_rvalid_q;

endmodule
